// File: rtl/rst_req_arb_pkg.sv
// Shared definitions for the reset request arbiter: FSM state encoding
// and the bit positions of the sticky reset-cause register.
package rst_req_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_HOLD   = 2'd2
    } arb_state_t;

    localparam int CAUSE_W   = 4;
    localparam int CAUSE_POR = 0;
    localparam int CAUSE_KEY = 1;
    localparam int CAUSE_MCU = 2;
    localparam int CAUSE_WDT = 3;

    localparam logic [CAUSE_W-1:0] CAUSE_POR_MASK = 4'b0001;

endpackage

// File: rtl/key_debounce.sv
// Reset pushbutton conditioning: two-flop synchronizer followed by a
// debouncer that accepts a new level only after it has been stable for
// 2^DEB_BITS consecutive cycles. Output is active-low (0 = pressed).
module key_debounce #(
    parameter int DEB_BITS = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw_n,
    output logic key_deb
);

    logic                sync_a;
    logic                sync_b;
    logic [DEB_BITS-1:0] deb_cnt;

    // Bring the asynchronous pushbutton into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
        end else begin
            sync_a <= key_raw_n;
            sync_b <= sync_a;
        end
    end

    // Count consecutive mismatch cycles; flip on the 2^DEB_BITS-th, restart on any match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_deb <= 1'b1;
            deb_cnt <= '0;
        end else if (sync_b != key_deb) begin
            if (deb_cnt == '1) begin
                key_deb <= sync_b;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end else begin
            deb_cnt <= '0;
        end
    end

endmodule

// File: rtl/rst_req_arb.sv
// Reset request arbiter: merges pushbutton, MCU and watchdog reset requests
// into one stretched, registered active-low reset request, and records the
// cause of each reset in a sticky, software-clearable register.
module rst_req_arb
    import rst_req_arb_pkg::*;
#(
    parameter int DEB_BITS     = 16,
    parameter int STRETCH_BITS = 8,
    parameter int WDT_BITS     = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_rst_n,
    input  logic               mcu_rst_req,
    input  logic               wdt_en,
    input  logic               wdt_kick,
    input  logic               cause_clr,
    output logic               rst_req_n,
    output logic [CAUSE_W-1:0] rst_cause
);

    arb_state_t              state;
    arb_state_t              state_nxt;
    logic [STRETCH_BITS-1:0] stretch_cnt;
    logic [STRETCH_BITS-1:0] stretch_nxt;
    logic [WDT_BITS-1:0]     wdt_cnt;
    logic                    key_deb;
    logic                    key_deb_q;
    logic                    key_press;
    logic                    wdt_timeout;
    logic                    any_req;
    logic [CAUSE_W-1:0]      cause_set;

    key_debounce #(
        .DEB_BITS (DEB_BITS)
    ) u_key_debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_raw_n (key_rst_n),
        .key_deb   (key_deb)
    );

    // A press is the debounced high-to-low transition; a kick masks a coincident timeout.
    assign key_press   = key_deb_q & ~key_deb;
    assign wdt_timeout = (state == ST_IDLE) & wdt_en & ~wdt_kick & (wdt_cnt == '1);
    assign any_req     = key_press | mcu_rst_req | wdt_timeout;

    // Previous debounced key level for press-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_deb_q <= 1'b1;
        end else begin
            key_deb_q <= key_deb;
        end
    end

    // Next-state logic: stretch the pulse, then hold while the key stays pressed.
    always_comb begin
        state_nxt   = state;
        stretch_nxt = stretch_cnt;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_nxt   = ST_ASSERT;
                    stretch_nxt = '0;
                end
            end
            ST_ASSERT: begin
                stretch_nxt = stretch_cnt + 1'b1;
                if (stretch_cnt == '1) begin
                    state_nxt = key_deb ? ST_IDLE : ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (key_deb) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, stretch counter and the registered reset request output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_ASSERT;
            stretch_cnt <= '0;
            rst_req_n   <= 1'b0;
        end else begin
            state       <= state_nxt;
            stretch_cnt <= stretch_nxt;
            rst_req_n   <= (state_nxt == ST_IDLE);
        end
    end

    // Watchdog runs only while enabled and idle; it wraps to 0 after the all-ones timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdt_cnt <= '0;
        end else if ((state != ST_IDLE) || !wdt_en || wdt_kick) begin
            wdt_cnt <= '0;
        end else begin
            wdt_cnt <= wdt_cnt + 1'b1;
        end
    end

    // Cause bits raised this cycle, regardless of FSM state.
    always_comb begin
        cause_set            = '0;
        cause_set[CAUSE_KEY] = key_press;
        cause_set[CAUSE_MCU] = mcu_rst_req;
        cause_set[CAUSE_WDT] = wdt_timeout;
    end

    // Sticky cause register; a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_cause <= CAUSE_POR_MASK;
        end else begin
            rst_cause <= (cause_clr ? '0 : rst_cause) | cause_set;
        end
    end

endmodule
